// File: rtl/enc_8b10b_multi.sv
// Multi-lane 8b/10b encoder (IEEE 802.3 clause 36 tables) with a two-stage pipeline,
// disparity chained across lanes, raw bypass, forced start disparity and an illegal-K counter.
module enc_8b10b_multi #(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [8*LANES-1:0]    D,
  input  logic [LANES-1:0]      K,
  input  logic                  VALID_IN,
  input  logic                  BYPASS,
  input  logic [10*LANES-1:0]   RAW,
  input  logic                  FORCE_DISP,
  input  logic                  DISP_SEL,
  output logic [10*LANES-1:0]   ENC,
  output logic                  VALID_OUT,
  output logic [LANES-1:0]      INVALID_K,
  output logic                  RD_OUT,
  output logic [CNT_W-1:0]      KERR_CNT
);

  localparam logic [9:0] K28_5_NEG = 10'b0011111010;

  // 5b/6b codes as seen from RD-, abcdei order.
  function automatic logic [5:0] sixb_neg(input logic [4:0] x);
    case (x)
      5'd0:  sixb_neg = 6'b100111;
      5'd1:  sixb_neg = 6'b011101;
      5'd2:  sixb_neg = 6'b101101;
      5'd3:  sixb_neg = 6'b110001;
      5'd4:  sixb_neg = 6'b110101;
      5'd5:  sixb_neg = 6'b101001;
      5'd6:  sixb_neg = 6'b011001;
      5'd7:  sixb_neg = 6'b111000;
      5'd8:  sixb_neg = 6'b111001;
      5'd9:  sixb_neg = 6'b100101;
      5'd10: sixb_neg = 6'b010101;
      5'd11: sixb_neg = 6'b110100;
      5'd12: sixb_neg = 6'b001101;
      5'd13: sixb_neg = 6'b101100;
      5'd14: sixb_neg = 6'b011100;
      5'd15: sixb_neg = 6'b010111;
      5'd16: sixb_neg = 6'b011011;
      5'd17: sixb_neg = 6'b100011;
      5'd18: sixb_neg = 6'b010011;
      5'd19: sixb_neg = 6'b110010;
      5'd20: sixb_neg = 6'b001011;
      5'd21: sixb_neg = 6'b101010;
      5'd22: sixb_neg = 6'b011010;
      5'd23: sixb_neg = 6'b111010;
      5'd24: sixb_neg = 6'b110011;
      5'd25: sixb_neg = 6'b100110;
      5'd26: sixb_neg = 6'b010110;
      5'd27: sixb_neg = 6'b110110;
      5'd28: sixb_neg = 6'b001110;
      5'd29: sixb_neg = 6'b101110;
      5'd30: sixb_neg = 6'b011110;
      5'd31: sixb_neg = 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] fourb_neg(input logic [2:0] y, input logic ctrl);
    case (y)
      3'd0: fourb_neg = 4'b1011;
      3'd1: fourb_neg = ctrl ? 4'b0110 : 4'b1001;
      3'd2: fourb_neg = ctrl ? 4'b1010 : 4'b0101;
      3'd3: fourb_neg = 4'b1100;
      3'd4: fourb_neg = 4'b1101;
      3'd5: fourb_neg = ctrl ? 4'b0101 : 4'b1010;
      3'd6: fourb_neg = ctrl ? 4'b1001 : 4'b0110;
      3'd7: fourb_neg = ctrl ? 4'b0111 : 4'b1110;
    endcase
  endfunction

  function automatic logic is_legal_k(input logic [7:0] b);
    is_legal_k = (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
                 (b == 8'hFD) || (b == 8'hFE);
  endfunction

  // Returns {ending RD, abcdeifghj}; ctrl must only be set for legal K codes.
  function automatic logic [10:0] encode_byte(input logic [7:0] b, input logic ctrl,
                                              input logic rd_in);
    logic [5:0] neg6;
    logic [5:0] six;
    logic [3:0] neg4;
    logic [3:0] four;
    logic       rd_mid;
    logic       alt;
    neg6 = (ctrl && b[4:0] == 5'd28) ? 6'b001111 : sixb_neg(b[4:0]);
    if (rd_in && b[4:0] == 5'd7)
      six = 6'b000111;
    else if (rd_in && ($countones(neg6) != 3))
      six = ~neg6;
    else
      six = neg6;
    rd_mid = rd_in ^ ($countones(six) != 3);
    // D.x.7 alternate avoids a run of five identical bits across the sub-block seam.
    alt = !ctrl && (b[7:5] == 3'd7) &&
          ((!rd_mid && six[1] && six[0]) || (rd_mid && !six[1] && !six[0]));
    neg4 = alt ? 4'b0111 : fourb_neg(b[7:5], ctrl);
    if (rd_mid && (ctrl || ($countones(neg4) != 2) || (b[7:5] == 3'd3)))
      four = ~neg4;
    else
      four = neg4;
    encode_byte = {rd_mid ^ ($countones(four) != 2), six, four};
  endfunction

  logic [8*LANES-1:0]  d_s1;
  logic [LANES-1:0]    k_s1;
  logic [10*LANES-1:0] raw_s1;
  logic                bypass_s1;
  logic                force_s1;
  logic                sel_s1;
  logic                valid_s1;

  logic [10*LANES-1:0] enc_q;
  logic [LANES-1:0]    invk_q;
  logic                valid_q;
  logic                rd_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [10*LANES-1:0] enc_next;
  logic [LANES-1:0]    invk_next;
  logic                rd_next;
  logic                rd_chain;
  logic [10:0]         lane_res;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_s1      <= '0;
      k_s1      <= '0;
      raw_s1    <= '0;
      bypass_s1 <= 1'b0;
      force_s1  <= 1'b0;
      sel_s1    <= 1'b0;
      valid_s1  <= 1'b0;
    end else begin
      valid_s1 <= VALID_IN;
      if (VALID_IN) begin
        d_s1      <= D;
        k_s1      <= K;
        raw_s1    <= RAW;
        bypass_s1 <= BYPASS;
        force_s1  <= FORCE_DISP;
        sel_s1    <= DISP_SEL;
      end
    end
  end

  always_comb begin
    rd_chain  = force_s1 ? sel_s1 : rd_q;
    enc_next  = '0;
    invk_next = '0;
    lane_res  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_res = encode_byte(d_s1[8*i +: 8], k_s1[i] && is_legal_k(d_s1[8*i +: 8]), rd_chain);
      invk_next[i] = k_s1[i] && !is_legal_k(d_s1[8*i +: 8]);
      enc_next[10*i +: 10] = lane_res[9:0];
      rd_chain = lane_res[10];
    end
    rd_next = rd_chain;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      enc_q   <= {LANES{K28_5_NEG}};
      invk_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_s1;
      if (valid_s1) begin
        if (bypass_s1) begin
          enc_q  <= raw_s1;
          invk_q <= '0;
        end else begin
          enc_q  <= enc_next;
          invk_q <= invk_next;
          rd_q   <= rd_next;
          if ((|invk_next) && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign ENC       = enc_q;
  assign INVALID_K = invk_q;
  assign VALID_OUT = valid_q;
  assign RD_OUT    = rd_q;
  assign KERR_CNT  = cnt_q;

endmodule

// File: tb/tb_enc_8b10b_multi.sv
// Self-checking bench for enc_8b10b_multi: directed vectors plus randomized words
// compared against a table-driven 8b/10b reference model with a timed scoreboard.
module tb_enc_8b10b_multi;

  localparam int LANES = 2;
  localparam int CNT_W = 4;
  localparam logic [9:0] K285N = 10'b0011111010;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [15:0] D = '0;
  logic [1:0]  K = '0;
  logic        VALID_IN = 1'b0;
  logic        BYPASS = 1'b0;
  logic [19:0] RAW = '0;
  logic        FORCE_DISP = 1'b0;
  logic        DISP_SEL = 1'b0;
  logic [19:0] ENC;
  logic        VALID_OUT;
  logic [1:0]  INVALID_K;
  logic        RD_OUT;
  logic [3:0]  KERR_CNT;

  enc_8b10b_multi #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .D(D), .K(K), .VALID_IN(VALID_IN), .BYPASS(BYPASS),
    .RAW(RAW), .FORCE_DISP(FORCE_DISP), .DISP_SEL(DISP_SEL), .ENC(ENC),
    .VALID_OUT(VALID_OUT), .INVALID_K(INVALID_K), .RD_OUT(RD_OUT), .KERR_CNT(KERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Both disparity columns written out as in the standard's tables.
  logic [5:0] c6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                           6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                           6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                           6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                           6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                           6'b011110, 6'b101011};
  logic [5:0] c6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
                           6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
                           6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
                           6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                           6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
                           6'b100001, 6'b010100};
  logic [3:0] c4dn [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] c4dp [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] c4kn [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] c4kp [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] legalK [12] = '{8'hBC, 8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hDC, 8'hFC,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};

  typedef struct {
    int         due;
    logic [19:0] enc;
    logic [1:0]  invk;
    logic        rd;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        modelRd = 1'b0;
  int          modelCnt = 0;
  logic [19:0] holdEnc = {2{K285N}};
  logic [1:0]  holdInvk = '0;
  logic        holdRd = 1'b0;
  logic [3:0]  holdCnt = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic blockRd(input logic rd, input int ones, input int width);
    if (2 * ones > width) return 1'b1;
    if (2 * ones < width) return 1'b0;
    return rd;
  endfunction

  task automatic refByte(input logic [7:0] b, input logic kin, input logic rdIn,
                         output logic [9:0] code, output logic rdOut, output logic bad);
    int x;
    int y;
    logic isK;
    logic [5:0] s;
    logic [3:0] f;
    logic r;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    isK = kin && (x == 28 || b == 8'hF7 || b == 8'hFB || b == 8'hFD || b == 8'hFE);
    bad = kin && !isK;
    if (isK && x == 28) s = rdIn ? 6'b110000 : 6'b001111;
    else s = rdIn ? c6p[x] : c6n[x];
    r = blockRd(rdIn, $countones(s), 6);
    if (isK) f = r ? c4kp[y] : c4kn[y];
    else if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) ||
                        (r && (x == 11 || x == 13 || x == 14)))) f = r ? 4'b1000 : 4'b0111;
    else f = r ? c4dp[y] : c4dn[y];
    rdOut = blockRd(r, $countones(f), 4);
    code = {s, f};
  endtask

  task automatic modelWord(input logic [15:0] d, input logic [1:0] k, input logic byp,
                           input logic [19:0] raw, input logic frc, input logic sel,
                           output exp_t e);
    logic r;
    logic ro;
    logic bad;
    logic [9:0] code;
    e.due = 0;
    e.enc = '0;
    e.invk = '0;
    if (byp) begin
      e.enc = raw;
    end else begin
      r = frc ? sel : modelRd;
      for (int i = 0; i < LANES; i++) begin
        refByte(d[8*i +: 8], k[i], r, code, ro, bad);
        e.enc[10*i +: 10] = code;
        e.invk[i] = bad;
        r = ro;
      end
      modelRd = r;
      if (e.invk != 0 && modelCnt < 15) modelCnt++;
    end
    e.rd = modelRd;
    e.cnt = 4'(modelCnt);
  endtask

  task automatic checkCycle();
    exp_t e;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      e = expQ.pop_front();
      checkOutput("valid_out", VALID_OUT, 1);
      holdEnc = e.enc;
      holdInvk = e.invk;
      holdRd = e.rd;
      holdCnt = e.cnt;
    end else begin
      checkOutput("valid_idle", VALID_OUT, 0);
    end
    checkOutput("enc", ENC, holdEnc);
    checkOutput("invalid_k", INVALID_K, holdInvk);
    checkOutput("rd_out", RD_OUT, holdRd);
    checkOutput("kerr_cnt", KERR_CNT, holdCnt);
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] k, input logic v,
                               input logic byp, input logic [19:0] raw, input logic frc,
                               input logic sel);
    exp_t e;
    D = d; K = k; VALID_IN = v; BYPASS = byp; RAW = raw; FORCE_DISP = frc; DISP_SEL = sel;
    if (v) begin
      modelWord(d, k, byp, raw, frc, sel, e);
      e.due = cyc + 2;
      expQ.push_back(e);
    end
    @(posedge CLK);
    #1;
    cyc++;
    checkCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    VALID_IN = 1'b0; BYPASS = 1'b0; FORCE_DISP = 1'b0; DISP_SEL = 1'b0;
    D = '0; K = '0; RAW = '0;
    expQ.delete();
    modelRd = 1'b0; modelCnt = 0;
    holdEnc = {2{K285N}}; holdInvk = '0; holdRd = 1'b0; holdCnt = '0;
    #2;
    checkOutput("rst_valid", VALID_OUT, 0);
    checkOutput("rst_enc", ENC, {2{K285N}});
    checkOutput("rst_invalid_k", INVALID_K, 0);
    checkOutput("rst_rd", RD_OUT, 0);
    checkOutput("rst_cnt", KERR_CNT, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      checkOutput("rst_valid_hold", VALID_OUT, 0);
      checkOutput("rst_enc_hold", ENC, {2{K285N}});
    end
    RST_N = 1'b1;
  endtask

  initial begin
    logic [15:0] rd16;
    logic [1:0]  rk;
    logic [19:0] rraw;
    #1;
    doReset();

    // Two K28.5 lanes chain RD- -> RD+ -> RD-.
    applyStimulus(16'hBCBC, 2'b11, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("k285_latency_idle", VALID_OUT, 0);
    idleCycles(1);
    checkOutput("k285_pair_enc", ENC, {10'b1100000101, 10'b0011111010});
    checkOutput("k285_pair_rd", RD_OUT, 0);

    applyStimulus(16'h0000, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("d00_enc", ENC, {10'b1001110100, 10'b1001110100});
    checkOutput("d00_rd", RD_OUT, 0);

    applyStimulus(16'h00BC, 2'b01, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    idleCycles(1);
    checkOutput("forced_k285_lane0", ENC[9:0], 10'b1100000101);
    checkOutput("forced_rd", RD_OUT, 0);

    // Illegal K0.0 words drive the counter into saturation.
    applyStimulus(16'h0000, 2'b01, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("badk_flag", INVALID_K, 2'b01);
    checkOutput("badk_lane0", ENC[9:0], 10'b1001110100);
    checkOutput("badk_cnt1", KERR_CNT, 1);
    for (int i = 0; i < 18; i++) applyStimulus(16'h0000, 2'b01, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("badk_cnt_sat", KERR_CNT, 4'hF);

    // RD+ must survive a gap and steer the next D0.0.
    applyStimulus(16'hBCB5, 2'b10, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(5);
    checkOutput("gap_rd_held", RD_OUT, 1);
    applyStimulus(16'h0000, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("after_gap_lane0", ENC[9:0], 10'b0110001011);

    // Reset with a word in flight: it must vanish and encoding restarts from RD-.
    applyStimulus(16'h00BC, 2'b01, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    D = 16'hBC00; K = 2'b10; VALID_IN = 1'b1;
    doReset();
    idleCycles(3);
    applyStimulus(16'h0000, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("post_reset_enc", ENC, {10'b1001110100, 10'b1001110100});

    for (int n = 0; n < 400; n++) begin
      rk = 2'($urandom_range(0, 3));
      rd16 = 16'($urandom);
      for (int l = 0; l < LANES; l++)
        if (rk[l] && $urandom_range(0, 3) != 0) rd16[8*l +: 8] = legalK[$urandom_range(0, 11)];
      rraw = 20'($urandom);
      applyStimulus(rd16, rk, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rraw,
                    $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
    end
    idleCycles(3);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
